icache_responder: RTL and testbench

- Memory-side responder for the instruction-cache request/response bus. It is the slave end of the fetch unit's master interface.
- Accepts tagged word requests, services reads from an internal word-addressed instruction RAM, and returns data with the request tag unchanged.
- Responses are in order and have a fixed latency. A credit-based response queue absorbs backpressure.
- Used as a cache-less / simulation instruction memory and as the responder model for fetch-path verification.

---
 rtl/icache_responder_if.sv | 32 +++
 rtl/icache_responder.sv | 133 +++++++++++++
 tb/tb_icache_responder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// icache_responder_if: request/response bus between the fetch unit and the
// instruction memory responder.
//   req_*  : tagged word request (read or byte-enabled write), valid/ready.
//   rsp_*  : in-order read response carrying the originating tag, valid/ready.
// Modports: master = fetch unit side, slave = memory responder side.
interface icache_responder_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH/8-1:0] req_byteen;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]    rsp_tag;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: memory-side responder for the instruction-cache bus.
// Reads are served from an internal word-addressed RAM with fixed latency and
// returned in order with the request tag; writes update byte lanes and produce
// no response. A credit counter bounds outstanding reads so the response FIFO
// can never overflow.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus (slave modport)   : req_* request channel, rsp_* response channel
//   ld_valid/addr/data    : backdoor full-word RAM load, blocks the bus
module icache_responder #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2,
  parameter int RSP_QUEUE  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  icache_responder_if.slave            bus,
  input  logic                         ld_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]        ld_data
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int CRED_W = $clog2(RSP_QUEUE) + 1;
  localparam int PTR_W  = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;
  localparam int ENT_W  = TAG_WIDTH + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [CRED_W-1:0]     credits;
  logic                  req_fire, rd_fire, wr_fire, rsp_fire;
  logic [IDX_W-1:0]      idx;
  logic [ENT_W-1:0]      rd_entry;
  logic                  fifo_push;
  logic [ENT_W-1:0]      fifo_in;
  logic [ENT_W-1:0]      fifo_mem [RSP_QUEUE];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CRED_W-1:0]     fifo_count;
  logic                  addr_unused;

  // Upper address bits are intentionally ignored: addresses wrap modulo MEM_DEPTH.
  assign idx         = bus.req_addr[IDX_W-1:0];
  assign addr_unused = ^bus.req_addr[ADDR_WIDTH-1:IDX_W];

  assign bus.req_ready = (credits < CRED_W'(RSP_QUEUE)) && !ld_valid;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign rd_fire       = req_fire && !bus.req_rw;
  assign wr_fire       = req_fire && bus.req_rw;
  assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

  // RAM is not reset; backdoor load wins (the bus is held off while it is active).
  always_ff @(posedge clk) begin
    if (ld_valid) begin
      mem[ld_addr] <= ld_data;
    end else if (wr_fire) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (bus.req_byteen[b]) mem[idx][b*8 +: 8] <= bus.req_data[b*8 +: 8];
      end
    end
  end

  // Read happens in the accept cycle; this counts as the first latency stage.
  assign rd_entry = {bus.req_tag, mem[idx]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= '0;
    end else if (rd_fire && !rsp_fire) begin
      credits <= credits + CRED_W'(1);
    end else if (!rd_fire && rsp_fire) begin
      credits <= credits - CRED_W'(1);
    end
  end

  // LATENCY-1 registered stages; the last hop writes the FIFO so that a read
  // accepted in cycle t is visible on rsp_* in cycle t+LATENCY.
  if (LATENCY == 1) begin : g_direct
    assign fifo_push = rd_fire;
    assign fifo_in   = rd_entry;
  end else begin : g_pipe
    logic             pipe_valid [LATENCY-1];
    logic [ENT_W-1:0] pipe_entry [LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) begin
          pipe_valid[i] <= 1'b0;
          pipe_entry[i] <= '0;
        end
      end else begin
        pipe_valid[0] <= rd_fire;
        pipe_entry[0] <= rd_entry;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_entry[i] <= pipe_entry[i-1];
        end
      end
    end

    assign fifo_push = pipe_valid[LATENCY-2];
    assign fifo_in   = pipe_entry[LATENCY-2];
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_QUEUE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is cleared on reset so rsp_data/rsp_tag read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < RSP_QUEUE; i++) fifo_mem[i] <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= fifo_in;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (rsp_fire) rd_ptr <= ptr_next(rd_ptr);
      case ({fifo_push, rsp_fire})
        2'b10:   fifo_count <= fifo_count + CRED_W'(1);
        2'b01:   fifo_count <= fifo_count - CRED_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.rsp_valid                = (fifo_count != '0);
  assign {bus.rsp_tag, bus.rsp_data}  = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: scoreboard of expected responses
// built from a reference memory model, plus per-scenario timing checks.
module tb_icache_responder;
  localparam int AW = 30, DW = 32, TW = 16, DEPTH = 1024, LAT = 2, RQ = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_valid;
  logic [9:0]    ld_addr;
  logic [DW-1:0] ld_data;

  always #5 clk = ~clk;

  icache_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

  icache_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .MEM_DEPTH(DEPTH), .LATENCY(LAT), .RSP_QUEUE(RQ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } exp_t;

  int            passed = 0;
  int            total = 0;
  int            rsp_count = 0;
  int            model_cred = 0;
  exp_t          sbq[$];
  exp_t          e;
  logic [DW-1:0] model [DEPTH];

  // Scoreboard monitor: inputs are driven just after posedge, so at negedge
  // everything that will fire on the next posedge is stable.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp got tag=%h data=%h want no response", bus.rsp_tag, bus.rsp_data);
        end else if (bus.rsp_ready === 1'b1) begin
          e = sbq.pop_front();
          total++;
          if ({bus.rsp_tag, bus.rsp_data} !== e)
            $display("FAIL sb_rsp got tag=%h data=%h want tag=%h data=%h", bus.rsp_tag, bus.rsp_data, e.tag, e.data);
          else passed++;
          rsp_count++;
          model_cred--;
        end
      end
      if (ld_valid === 1'b1) begin
        model[ld_addr] = ld_data;
      end else if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
        if (bus.req_rw) begin
          for (int b = 0; b < DW / 8; b++)
            if (bus.req_byteen[b]) model[bus.req_addr[9:0]][b*8 +: 8] = bus.req_data[b*8 +: 8];
        end else begin
          sbq.push_back({bus.req_tag, model[bus.req_addr[9:0]]});
          model_cred++;
        end
      end
      if (model_cred > RQ) begin
        total++;
        $display("FAIL credit_overflow got %0d outstanding want <= %0d", model_cred, RQ);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [AW-1:0] addr, input logic [3:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag);
    bus.req_valid  = 1'b1;
    bus.req_rw     = rw;
    bus.req_addr   = addr;
    bus.req_byteen = be;
    bus.req_data   = data;
    bus.req_tag    = tag;
  endtask

  task automatic load(input logic [9:0] idx, input logic [DW-1:0] data);
    step();
    ld_valid = 1'b1;
    ld_addr  = idx;
    ld_data  = data;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_data !== '0) $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); else passed++;
    total++; if (bus.rsp_tag !== '0) $display("FAIL reset_rsp_tag got %h want 0", bus.rsp_tag); else passed++;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", bus.req_ready); else passed++;
  endtask

  task automatic test_single_read();
    step();
    ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) $display("FAIL ld_blocks_ready got %b want 0", bus.req_ready); else passed++;
    step();
    ld_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 30'd5, 4'h0, '0, 16'h00A3);
    @(negedge clk);
    total++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) $display("FAIL single_t got ready,valid=%b want 10", {bus.req_ready, bus.rsp_valid}); else passed++;
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_t1 got %b want 0", bus.rsp_valid); else passed++;
    step();
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_data} !== {1'b1, 16'h00A3, 32'hDEADBEEF})
      $display("FAIL single_t2 got v=%b tag=%h data=%h want v=1 tag=00a3 data=deadbeef", bus.rsp_valid, bus.rsp_tag, bus.rsp_data);
    else passed++;
    step();
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_t3 got %b want 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic got = 1'b0;
    step();
    drive(1'b0, 30'h405, 4'h0, '0, 16'h001B);
    @(negedge clk);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) $display("FAIL wrap_timeout got no rsp want rsp");
    else if (bus.rsp_data !== 32'hDEADBEEF) $display("FAIL wrap_data got %h want deadbeef", bus.rsp_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) load(10'(i), 32'h1000_0000 + i);
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b0, 30'(i), 4'h0, '0, 16'(i));
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b want 1", i, bus.req_ready); else passed++;
      if (i >= 2) begin
        total++;
        if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 16'(i - 2)})
          $display("FAIL b2b_rsp_%0d got v=%b tag=%h want v=1 tag=%h", i - 2, bus.rsp_valid, bus.rsp_tag, 16'(i - 2));
        else passed++;
      end
    end
    step();
    bus.req_valid = 1'b0;
    for (int j = 6; j < 8; j++) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 16'(j)})
        $display("FAIL b2b_rsp_%0d got v=%b tag=%h want v=1 tag=%h", j, bus.rsp_valid, bus.rsp_tag, 16'(j));
      else passed++;
      step();
    end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_backpressure();
    int  cnt0;
    logic done = 1'b0;
    for (int i = 0; i < 6; i++) load(10'(16 + i), 32'hA0A0_0000 + i);
    cnt0 = rsp_count;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1'b0, 30'(16 + k), 4'h0, '0, 16'(32'h20 + k));
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1) $display("FAIL bp_accept_%0d got %b want 1", k, bus.req_ready); else passed++;
    end
    step();
    drive(1'b0, 30'd20, 4'h0, '0, 16'h0024);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) $display("FAIL bp_full got %b want 0", bus.req_ready); else passed++;
    step();
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_tag} !== {1'b0, 1'b1, 16'h0020})
      $display("FAIL bp_hold got rdy=%b v=%b tag=%h want rdy=0 v=1 tag=0020", bus.req_ready, bus.rsp_valid, bus.rsp_tag);
    else passed++;
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) $display("FAIL bp_fire_cycle got %b want 0", bus.req_ready); else passed++;
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL bp_reopen got %b want 1", bus.req_ready); else passed++;
    step();
    drive(1'b0, 30'd21, 4'h0, '0, 16'h0025);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL bp_last got %b want 1", bus.req_ready); else passed++;
    step();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      if (model_cred == 0 && sbq.size() == 0) done = 1'b1;
    end
    #1;
    @(negedge clk);
    total++;
    if (!done || rsp_count - cnt0 != 6 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL bp_drain got done=%b rsps=%0d v=%b rdy=%b want done=1 rsps=6 v=0 rdy=1", done, rsp_count - cnt0, bus.rsp_valid, bus.req_ready);
    else passed++;
  endtask

  task automatic test_write_merge();
    int   cnt0;
    logic got = 1'b0;
    load(10'd5, 32'hDEADBEEF);
    cnt0 = rsp_count;
    step();
    drive(1'b1, 30'd5, 4'b0101, 32'h11223344, 16'h0077);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL wr_ready got %b want 1", bus.req_ready); else passed++;
    step();
    drive(1'b0, 30'd5, 4'h0, '0, 16'h0055);
    @(negedge clk);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got %b want 0", bus.rsp_valid); else passed++;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.rsp_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got) $display("FAIL raw_timeout got no rsp want rsp");
    else if ({bus.rsp_tag, bus.rsp_data} !== {16'h0055, 32'hDE22BE44})
      $display("FAIL raw_data got tag=%h data=%h want tag=0055 data=de22be44", bus.rsp_tag, bus.rsp_data);
    else passed++;
    repeat (4) step();
    total++; if (rsp_count - cnt0 != 1) $display("FAIL wr_rsp_count got %0d want 1", rsp_count - cnt0); else passed++;
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b0, 30'(k), 4'h0, '0, 16'(32'h30 + k));
    end
    step();
    bus.req_valid = 1'b0;
    step();
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_pending got %b want 1", bus.rsp_valid); else passed++;
    step();
    reset_n = 1'b0;
    sbq.delete();
    model_cred = 0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", bus.rsp_valid); else passed++;
    repeat (2) step();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL mid_release_ready got %b want 1", bus.req_ready); else passed++;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_stale_%0d got %b want 0", c, bus.rsp_valid); else passed++;
    end
    step();
    drive(1'b0, 30'd5, 4'h0, '0, 16'h0066);
    @(negedge clk);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) $display("FAIL mid_persist_timeout got no rsp want rsp");
    else if (bus.rsp_data !== 32'hDE22BE44) $display("FAIL mid_persist got %h want de22be44", bus.rsp_data);
    else passed++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_rw     = 1'b0;
    bus.req_addr   = '0;
    bus.req_byteen = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = 1'b0;
    ld_valid       = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    test_reset();
    test_single_read();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_write_merge();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
